// File: rtl/gain_calibrator_pkg.sv
// Shared types and constants for the gain calibrator: FSM states, default widths,
// and the unity/saturation gain codes at those widths.
package gain_calibrator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_MEAN,
    ST_DIVIDE,
    ST_PUBLISH
  } cal_state_t;

  localparam int DEF_MAG_WIDTH  = 26;
  localparam int DEF_GAIN_WIDTH = 27;
  localparam int DEF_LOG2_AVG   = 4;

  localparam logic [DEF_GAIN_WIDTH-1:0] UNITY_GAIN = DEF_GAIN_WIDTH'(1) << (DEF_GAIN_WIDTH - 1);
  localparam logic [DEF_GAIN_WIDTH-1:0] SAT_GAIN   = {DEF_GAIN_WIDTH{1'b1}};
  localparam int                        DIV_CYCLES = DEF_GAIN_WIDTH + 1;

endpackage

// File: rtl/gain_calibrator_divider.sv
// Serial unsigned restoring divider: one quotient bit per cycle, the first bit
// resolved on the load edge so the quotient is valid QUOTIENT_WIDTH cycles after load.
module gain_divider #(
  parameter int DIVIDEND_WIDTH = 52,
  parameter int DIVISOR_WIDTH  = 26,
  parameter int QUOTIENT_WIDTH = 27
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic [QUOTIENT_WIDTH-1:0] quotient,
  output logic                      done
);

  localparam int CNT_WIDTH = $clog2(QUOTIENT_WIDTH + 1);

  logic [DIVISOR_WIDTH-1:0]  rem_reg;
  logic [QUOTIENT_WIDTH-1:0] dvd_reg;
  logic [QUOTIENT_WIDTH-1:0] quo_reg;
  logic [CNT_WIDTH-1:0]      cnt_reg;
  logic                      done_reg;

  logic [DIVISOR_WIDTH-1:0] rem_in;
  logic                     bit_in;
  logic [DIVISOR_WIDTH:0]   trial;
  logic                     fits;
  logic [DIVISOR_WIDTH-1:0] rem_step;

  // Caller guarantees dividend >> QUOTIENT_WIDTH < divisor, so the partial
  // remainder always fits in DIVISOR_WIDTH bits.
  always_comb begin
    rem_in = rem_reg;
    bit_in = dvd_reg[QUOTIENT_WIDTH-1];
    if (load) begin
      rem_in = DIVISOR_WIDTH'(dividend[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH]);
      bit_in = dividend[QUOTIENT_WIDTH-1];
    end
    trial    = {rem_in, bit_in};
    fits     = (trial >= {1'b0, divisor});
    rem_step = fits ? DIVISOR_WIDTH'(trial - {1'b0, divisor}) : trial[DIVISOR_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg  <= '0;
      dvd_reg  <= '0;
      quo_reg  <= '0;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else if (load) begin
      rem_reg  <= rem_step;
      dvd_reg  <= {dividend[QUOTIENT_WIDTH-2:0], 1'b0};
      quo_reg  <= {{(QUOTIENT_WIDTH-1){1'b0}}, fits};
      cnt_reg  <= CNT_WIDTH'(QUOTIENT_WIDTH - 1);
      done_reg <= 1'b0;
    end else if (cnt_reg != '0) begin
      rem_reg  <= rem_step;
      dvd_reg  <= {dvd_reg[QUOTIENT_WIDTH-2:0], 1'b0};
      quo_reg  <= {quo_reg[QUOTIENT_WIDTH-2:0], fits};
      cnt_reg  <= cnt_reg - 1'b1;
      done_reg <= (cnt_reg == CNT_WIDTH'(1));
    end else begin
      done_reg <= 1'b0;
    end
  end

  assign quotient = quo_reg;
  assign done     = done_reg;

endmodule

// File: rtl/gain_calibrator.sv
// Averages a burst of four-channel magnitudes and computes per-channel gains
// that pull each channel to the common mean; publishes them with a toggle handshake.
module gain_calibrator
  import gain_calibrator_pkg::*;
#(
  parameter int MAG_WIDTH  = DEF_MAG_WIDTH,
  parameter int GAIN_WIDTH = DEF_GAIN_WIDTH,
  parameter int LOG2_AVG   = DEF_LOG2_AVG
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    strobe,
  input  logic [4*MAG_WIDTH-1:0]  magnitudes,
  output logic [4*GAIN_WIDTH-1:0] gains,
  output logic                    gainsToggle,
  output logic                    done,
  output logic                    busy,
  output logic [3:0]              clipped
);

  localparam int ACC_WIDTH = MAG_WIDTH + LOG2_AVG;
  localparam int DVD_WIDTH = MAG_WIDTH + GAIN_WIDTH - 1;
  localparam int CYC_WIDTH = $clog2(GAIN_WIDTH + 1);

  localparam logic [GAIN_WIDTH-1:0] UNITY       = {1'b1, {(GAIN_WIDTH-1){1'b0}}};
  localparam logic [GAIN_WIDTH-1:0] SAT         = {GAIN_WIDTH{1'b1}};
  localparam logic [CYC_WIDTH-1:0]  LAST_CYC    = CYC_WIDTH'(GAIN_WIDTH);
  localparam logic [LOG2_AVG-1:0]   LAST_SAMPLE = {LOG2_AVG{1'b1}};

  cal_state_t state_reg, state_next;

  logic [LOG2_AVG-1:0]   sample_cnt_reg;
  logic [ACC_WIDTH-1:0]  acc_reg [4];
  logic [MAG_WIDTH-1:0]  mean [4];
  logic [MAG_WIDTH+1:0]  mean_sum;
  logic [MAG_WIDTH-1:0]  target_reg;
  logic [1:0]            ch_reg;
  logic [CYC_WIDTH-1:0]  cyc_reg;
  logic [GAIN_WIDTH-1:0] shadow_reg [4];
  logic [3:0]            clip_shadow_reg;
  logic                  special_reg;
  logic [GAIN_WIDTH-1:0] special_val_reg;

  logic [4*GAIN_WIDTH-1:0] gains_reg;
  logic                    toggle_reg;
  logic                    done_reg;
  logic [3:0]              clipped_reg;

  logic                    accept_start;
  logic                    take_sample;
  logic                    div_load;
  logic [MAG_WIDTH-1:0]    divisor;
  logic                    mean_zero;
  logic                    mean_sat;
  logic [GAIN_WIDTH-1:0]   quotient;
  logic                    div_done;

  assign accept_start = (state_reg == ST_IDLE) && start;
  assign take_sample  = (state_reg == ST_ACCUM) && strobe;

  for (genvar gi = 0; gi < 4; gi++) begin : g_chan
    assign mean[gi] = acc_reg[gi][ACC_WIDTH-1:LOG2_AVG];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_reg[gi] <= '0;
      end else if (accept_start) begin
        acc_reg[gi] <= '0;
      end else if (take_sample) begin
        acc_reg[gi] <= acc_reg[gi] + ACC_WIDTH'(magnitudes[gi*MAG_WIDTH +: MAG_WIDTH]);
      end
    end
  end

  assign mean_sum = (MAG_WIDTH+2)'(mean[0]) + (MAG_WIDTH+2)'(mean[1])
                  + (MAG_WIDTH+2)'(mean[2]) + (MAG_WIDTH+2)'(mean[3]);

  // A target of twice the mean or more would need a quotient beyond GAIN_WIDTH bits.
  assign divisor   = mean[ch_reg];
  assign mean_zero = (divisor == '0);
  assign mean_sat  = ({1'b0, target_reg} >= {divisor, 1'b0});

  gain_divider #(
    .DIVIDEND_WIDTH (DVD_WIDTH),
    .DIVISOR_WIDTH  (MAG_WIDTH),
    .QUOTIENT_WIDTH (GAIN_WIDTH)
  ) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .dividend ({target_reg, {(GAIN_WIDTH-1){1'b0}}}),
    .divisor  (divisor),
    .quotient (quotient),
    .done     (div_done)
  );

  always_comb begin
    state_next = state_reg;
    div_load   = 1'b0;
    busy       = (state_reg != ST_IDLE);
    unique case (state_reg)
      ST_IDLE:    if (start) state_next = ST_ACCUM;
      ST_ACCUM:   if (strobe && sample_cnt_reg == LAST_SAMPLE) state_next = ST_MEAN;
      ST_MEAN:    state_next = ST_DIVIDE;
      ST_DIVIDE: begin
        div_load = (cyc_reg == '0);
        if (cyc_reg == LAST_CYC && ch_reg == 2'd3) state_next = ST_PUBLISH;
      end
      ST_PUBLISH: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_reg  <= '0;
      target_reg      <= '0;
      ch_reg          <= '0;
      cyc_reg         <= '0;
      shadow_reg      <= '{default: UNITY};
      clip_shadow_reg <= '0;
      special_reg     <= 1'b0;
      special_val_reg <= UNITY;
      gains_reg       <= {4{UNITY}};
      toggle_reg      <= 1'b0;
      done_reg        <= 1'b0;
      clipped_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (start) sample_cnt_reg <= '0;
        end
        ST_ACCUM: begin
          if (strobe) sample_cnt_reg <= sample_cnt_reg + 1'b1;
        end
        ST_MEAN: begin
          target_reg <= mean_sum[MAG_WIDTH+1:2];
          ch_reg     <= '0;
          cyc_reg    <= '0;
        end
        ST_DIVIDE: begin
          if (cyc_reg == '0) begin
            special_reg             <= mean_zero || mean_sat;
            special_val_reg         <= mean_zero ? UNITY : SAT;
            clip_shadow_reg[ch_reg] <= mean_zero || mean_sat;
          end
          if (div_done) begin
            shadow_reg[ch_reg] <= special_reg ? special_val_reg : quotient;
          end
          if (cyc_reg == LAST_CYC) begin
            cyc_reg <= '0;
            ch_reg  <= ch_reg + 1'b1;
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
          end
        end
        ST_PUBLISH: begin
          for (int i = 0; i < 4; i++) begin
            gains_reg[i*GAIN_WIDTH +: GAIN_WIDTH] <= shadow_reg[i];
          end
          clipped_reg <= clip_shadow_reg;
          toggle_reg  <= ~toggle_reg;
          done_reg    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gains       = gains_reg;
  assign gainsToggle = toggle_reg;
  assign done        = done_reg;
  assign clipped     = clipped_reg;

endmodule

// File: tb/tb_gain_calibrator.sv
// Directed bench for gain_calibrator: stimulus pushes expected gain sets into a
// queue, a monitor pops and compares whenever done is seen.
module tb_gain_calibrator;
  import gain_calibrator_pkg::*;

  localparam int MW  = DEF_MAG_WIDTH;
  localparam int GW  = DEF_GAIN_WIDTH;
  localparam int LAT = 2 + 4 * DIV_CYCLES;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              strobe = 1'b0;
  logic [4*MW-1:0]   magnitudes = '0;
  logic [4*GW-1:0]   gains;
  logic              gainsToggle;
  logic              done;
  logic              busy;
  logic [3:0]        clipped;

  typedef struct {
    logic [4*GW-1:0] gains;
    logic [3:0]      clipped;
    logic            toggle;
    int unsigned     at_cycle;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cycle_cnt = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_pub = 0;
  logic        exp_toggle = 1'b0;

  gain_calibrator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .strobe      (strobe),
    .magnitudes  (magnitudes),
    .gains       (gains),
    .gainsToggle (gainsToggle),
    .done        (done),
    .busy        (busy),
    .clipped     (clipped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [4*GW-1:0] pack4(input logic [GW-1:0] g0, input logic [GW-1:0] g1,
                                            input logic [GW-1:0] g2, input logic [GW-1:0] g3);
    return {g3, g2, g1, g0};
  endfunction

  task automatic set_mags(input int m0, input int m1, input int m2, input int m3);
    magnitudes = {MW'(m3), MW'(m2), MW'(m1), MW'(m0)};
  endtask

  // Start pulse with a coincident strobe of huge values that must not be counted.
  task automatic do_start();
    @(negedge clk);
    set_mags(26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF);
    start  = 1'b1;
    strobe = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    strobe = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic send_samples(input int m0, input int m1, input int m2, input int m3,
                              input int max_gap, output int unsigned last_edge);
    set_mags(m0, m1, m2, m3);
    last_edge = 0;
    for (int s = 0; s < 16; s++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
      strobe = 1'b0;
      repeat (gap) @(negedge clk);
      strobe    = 1'b1;
      last_edge = cycle_cnt + 1;
      @(negedge clk);
    end
    strobe = 1'b0;
  endtask

  task automatic expect_set(input logic [4*GW-1:0] g, input logic [3:0] c, input int unsigned last_edge);
    exp_t e;
    exp_toggle = ~exp_toggle;
    e.gains    = g;
    e.clipped  = c;
    e.toggle   = exp_toggle;
    e.at_cycle = last_edge + LAT;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check("publish_timeout", exp_q.size(), 0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_pub++;
        $display("publish %0d: gains=%h clipped=%b toggle=%0d cycle=%0d",
                 n_pub, gains, clipped, gainsToggle, cycle_cnt);
        if (exp_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("gains", gains, e.gains);
          check("clipped", clipped, e.clipped);
          check("toggle", gainsToggle, e.toggle);
          check("done_cycle", cycle_cnt, e.at_cycle);
        end
      end
    end
  end

  initial begin : stimulus
    int unsigned last;
    repeat (3) @(negedge clk);
    check("reset_gains", gains, pack4(UNITY_GAIN, UNITY_GAIN, UNITY_GAIN, UNITY_GAIN));
    check("reset_toggle", gainsToggle, 0);
    check("reset_busy", busy, 0);
    check("reset_clipped", clipped, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;

    // Strobes without start are ignored.
    set_mags(100, 200, 300, 400);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      strobe = ~strobe;
    end
    strobe = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_gains", gains, pack4(UNITY_GAIN, UNITY_GAIN, UNITY_GAIN, UNITY_GAIN));
    check("idle_toggle", gainsToggle, 0);

    // Equal channels -> unity; start coincident with PUBLISH must be ignored.
    do_start();
    send_samples(1000, 1000, 1000, 1000, 0, last);
    expect_set(pack4(27'h4000000, 27'h4000000, 27'h4000000, 27'h4000000), 4'b0000, last);
    while (cycle_cnt != last + LAT - 1) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_publish", busy, 0);
    @(negedge clk);
    check("start_at_publish_ignored", busy, 0);
    wait_drain();

    // Unequal channels with random gaps.
    do_start();
    send_samples(1500, 2000, 2000, 2500, 5, last);
    expect_set(pack4(27'h5555555, 27'h4000000, 27'h4000000, 27'h3333333), 4'b0000, last);
    wait_drain();

    // Saturation on channels 0/1; a second start mid-DIVIDE is ignored.
    do_start();
    send_samples(1000, 1000, 2000, 4000, 0, last);
    expect_set(pack4(SAT_GAIN, SAT_GAIN, 27'h4000000, 27'h2000000), 4'b0011, last);
    while (cycle_cnt != last + 49) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_mid_divide", busy, 1);
    wait_drain();
    repeat (150) @(negedge clk);
    check("busy_after_ignored_start", busy, 0);

    // Zero-mean channel 2 -> unity and clipped.
    do_start();
    send_samples(1000, 1000, 0, 1000, 0, last);
    expect_set(pack4(27'h3000000, 27'h3000000, UNITY_GAIN, 27'h3000000), 4'b0100, last);
    wait_drain();

    // Reset mid-DIVIDE: outputs return to reset values, nothing published.
    do_start();
    send_samples(1500, 2000, 2000, 2500, 0, last);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    exp_toggle = 1'b0;
    #1;
    check("midreset_gains", gains, pack4(UNITY_GAIN, UNITY_GAIN, UNITY_GAIN, UNITY_GAIN));
    check("midreset_toggle", gainsToggle, 0);
    check("midreset_busy", busy, 0);
    check("midreset_clipped", clipped, 0);
    check("midreset_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check("publish_count", n_pub, 4);
    check("post_reset_toggle", gainsToggle, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
